// File: rtl/ex_div_unit.sv
// ex_div_unit: iterative restoring 32-bit divider for EX with stall/ready handshake
// Ports: clk, rst (async, active-high); EX_div_en/op/src1/src2 issue a divide;
// flush kills the in-flight divide; div_stall holds IF/ID/EX while iterating;
// div_ready pulses for one cycle with div_result (quotient or remainder).
// Optional build macro DIV_FAST_PATH_EN: zero divisor or |src1| < |src2| finish in one cycle.
module ex_div_unit #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EX_div_en,
    input  logic [1:0]       EX_div_op,
    input  logic [DIV_W-1:0] EX_div_src1,
    input  logic [DIV_W-1:0] EX_div_src2,
    input  logic             flush,
    output logic             div_stall,
    output logic             div_ready,
    output logic [DIV_W-1:0] div_result
);
    localparam int CW = $clog2(DIV_W);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic rem_sel, qs, rs, dz, s1, s2, start, fast, last;
    logic [DIV_W-1:0] src1_q, dvs, a, b, q, r, res, fres;
    logic [2*DIV_W-1:0] rq, rq_n;
    logic [DIV_W:0] t;
    assign start = state == IDLE && EX_div_en && !flush;
    assign last = cnt == CW'(DIV_W - 1);
    assign s1 = !EX_div_op[1] && EX_div_src1[DIV_W-1];
    assign s2 = !EX_div_op[1] && EX_div_src2[DIV_W-1];
    assign a = s1 ? -EX_div_src1 : EX_div_src1;
    assign b = s2 ? -EX_div_src2 : EX_div_src2;
`ifdef DIV_FAST_PATH_EN
    assign fast = b == '0 || a < b;
`else
    assign fast = 1'b0;
`endif
    // One restoring step: the shifted remainder needs 33 bits for the trial subtract.
    assign t = rq[2*DIV_W-1:DIV_W-1] - {1'b0, dvs};
    assign rq_n = t[DIV_W] ? {rq[2*DIV_W-2:0], 1'b0} : {t[DIV_W-1:0], rq[DIV_W-2:0], 1'b1};
    assign q = rq_n[DIV_W-1:0];
    assign r = rq_n[2*DIV_W-1:DIV_W];
    // Zero divisor bypasses the sign fix; remainder is the raw dividend.
    assign res = dz ? (rem_sel ? src1_q : '1) : rem_sel ? (rs ? -r : r) : (qs ? -q : q);
    // Fast path only fires when quotient is 0 (or all ones for /0) and remainder is src1.
    assign fres = EX_div_op[0] ? EX_div_src1 : (b == '0 ? '1 : '0);
    assign div_stall = !rst && (start || (state == BUSY && !flush));
    assign div_ready = state == DONE && !flush;
    always_comb begin
        state_n = flush ? IDLE :
                  state == IDLE ? (start ? (fast ? DONE : BUSY) : IDLE) :
                  state == BUSY ? (last ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            rq <= '0;
            rem_sel <= 1'b0;
            qs <= 1'b0;
            rs <= 1'b0;
            dz <= 1'b0;
            src1_q <= '0;
            dvs <= '0;
            div_result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
            rq <= {{DIV_W{1'b0}}, a};
            rem_sel <= EX_div_op[0];
            qs <= s1 ^ s2;
            rs <= s1;
            dz <= EX_div_src2 == '0;
            src1_q <= EX_div_src1;
            dvs <= b;
            if (fast) div_result <= fres;
        end else if (state == BUSY) begin
            rq <= rq_n;
            cnt <= cnt + 1'b1;
            if (last) div_result <= res;
        end
    end
endmodule
